dds_sweep_scheduler: RTL and testbench

Sequences the DDS compiler phase-increment channel through up to NUM_PROFILES frequency-sweep profiles: start, stop, step and dwell per profile. It selects enabled profiles round-robin, emits one AXI-Stream phase-increment beat per sweep point and holds each point for a programmable dwell. It sits between the control register bank and the DDS compiler s_axis_phase port, replacing fixed-constant sweep generation.

---
 rtl/dds_sweep_pkg.sv | 22 ++
 rtl/dds_sweep_profile_regs.sv | 52 +++++
 rtl/dds_sweep_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_dds_sweep_scheduler.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared types and constants for the DDS frequency-sweep scheduler.
// Field codes select which per-profile register a configuration write targets.
package dds_sweep_pkg;

  localparam int unsigned DEF_NUM_PROFILES = 4;
  localparam int unsigned DEF_PINC_W       = 32;
  localparam int unsigned DEF_DWELL_W      = 16;

  localparam logic [1:0] FLD_START = 2'd0;
  localparam logic [1:0] FLD_STOP  = 2'd1;
  localparam logic [1:0] FLD_STEP  = 2'd2;
  localparam logic [1:0] FLD_DWELL = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StDwell,
    StFinish
  } state_e;

endpackage

// File: rtl/dds_sweep_profile_regs.sv
// Register file holding start/stop/step/dwell for every sweep profile.
// One write port addressed by profile and field, one combinational read port.
module dds_sweep_profile_regs
  import dds_sweep_pkg::*;
#(
  parameter int unsigned NUM_PROFILES = DEF_NUM_PROFILES,
  parameter int unsigned PINC_W       = DEF_PINC_W,
  parameter int unsigned DWELL_W      = DEF_DWELL_W
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_we,
  input  logic [$clog2(NUM_PROFILES)-1:0] i_wr_idx,
  input  logic [1:0]                      i_field,
  input  logic [PINC_W-1:0]               i_wdata,
  input  logic [$clog2(NUM_PROFILES)-1:0] i_rd_idx,
  output logic [PINC_W-1:0]               o_start,
  output logic [PINC_W-1:0]               o_stop,
  output logic [PINC_W-1:0]               o_step,
  output logic [DWELL_W-1:0]              o_dwell
);

  logic [PINC_W-1:0]  r_start [NUM_PROFILES];
  logic [PINC_W-1:0]  r_stop  [NUM_PROFILES];
  logic [PINC_W-1:0]  r_step  [NUM_PROFILES];
  logic [DWELL_W-1:0] r_dwell [NUM_PROFILES];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_PROFILES; i++) begin
        r_start[i] <= '0;
        r_stop[i]  <= '0;
        r_step[i]  <= '0;
        r_dwell[i] <= '0;
      end
    end else if (i_we) begin
      case (i_field)
        FLD_START: r_start[i_wr_idx] <= i_wdata;
        FLD_STOP:  r_stop[i_wr_idx]  <= i_wdata;
        FLD_STEP:  r_step[i_wr_idx]  <= i_wdata;
        FLD_DWELL: r_dwell[i_wr_idx] <= i_wdata[DWELL_W-1:0];
        default:   ;
      endcase
    end
  end

  assign o_start = r_start[i_rd_idx];
  assign o_stop  = r_stop[i_rd_idx];
  assign o_step  = r_step[i_rd_idx];
  assign o_dwell = r_dwell[i_rd_idx];

endmodule

// File: rtl/dds_sweep_scheduler.sv
// Walks enabled sweep profiles round-robin and streams one phase-increment beat
// per sweep point to the DDS compiler, holding each point for its dwell time.
module dds_sweep_scheduler
  import dds_sweep_pkg::*;
#(
  parameter int unsigned NUM_PROFILES = DEF_NUM_PROFILES,
  parameter int unsigned PINC_W       = DEF_PINC_W,
  parameter int unsigned DWELL_W      = DEF_DWELL_W
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_cfg_we,
  input  logic [$clog2(NUM_PROFILES)-1:0] i_cfg_profile,
  input  logic [1:0]                      i_cfg_field,
  input  logic [PINC_W-1:0]               i_cfg_wdata,
  input  logic [NUM_PROFILES-1:0]         i_enable_mask,
  input  logic                            i_continuous,
  input  logic                            i_start,
  input  logic                            i_abort,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [$clog2(NUM_PROFILES)-1:0] o_cur_profile,
  output logic                            o_m_axis_phase_tvalid,
  input  logic                            i_m_axis_phase_tready,
  output logic [PINC_W-1:0]               o_m_axis_phase_tdata,
  output logic                            o_m_axis_phase_tlast
);

  localparam int unsigned IDX_W = $clog2(NUM_PROFILES);

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cur, w_cur_nxt;
  logic [PINC_W-1:0]  r_freq, w_freq_nxt;
  logic [PINC_W-1:0]  r_stop, r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_done, w_done_nxt;
  logic               r_abort, w_abort_nxt;

  logic [PINC_W-1:0]  w_rd_start, w_rd_stop, w_rd_step;
  logic [DWELL_W-1:0] w_rd_dwell;

  logic [PINC_W:0]    w_sum;
  logic               w_last;
  logic               w_abort_req;
  logic               w_hs;

  logic               w_low_found, w_up_found;
  logic [IDX_W-1:0]   w_low_idx, w_up_idx;

  state_e             w_adv_state;
  logic [IDX_W-1:0]   w_adv_cur;
  logic [PINC_W-1:0]  w_adv_freq;

  dds_sweep_profile_regs #(
    .NUM_PROFILES (NUM_PROFILES),
    .PINC_W       (PINC_W),
    .DWELL_W      (DWELL_W)
  ) u_profile_regs (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_we     (i_cfg_we),
    .i_wr_idx (i_cfg_profile),
    .i_field  (i_cfg_field),
    .i_wdata  (i_cfg_wdata),
    .i_rd_idx (r_cur),
    .o_start  (w_rd_start),
    .o_stop   (w_rd_stop),
    .o_step   (w_rd_step),
    .o_dwell  (w_rd_dwell)
  );

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    w_low_found = 1'b0;
    w_low_idx   = '0;
    w_up_found  = 1'b0;
    w_up_idx    = '0;
    for (int i = NUM_PROFILES - 1; i >= 0; i--) begin
      if (i_enable_mask[i]) begin
        w_low_found = 1'b1;
        w_low_idx   = IDX_W'(i);
        if (i > int'(r_cur)) begin
          w_up_found = 1'b1;
          w_up_idx   = IDX_W'(i);
        end
      end
    end
  end

  // One extra bit catches wrap past the top of the phase-increment range.
  assign w_sum  = {1'b0, r_freq} + {1'b0, r_step};
  assign w_last = (r_step == '0) | w_sum[PINC_W] | (w_sum[PINC_W-1:0] > r_stop);

  assign w_abort_req = i_abort | r_abort;
  assign w_hs        = (r_state == StSend) & i_m_axis_phase_tready;

  always_comb begin
    w_adv_state = StFinish;
    w_adv_cur   = r_cur;
    w_adv_freq  = r_freq;
    if (!w_last) begin
      w_adv_state = StSend;
      w_adv_freq  = w_sum[PINC_W-1:0];
    end else if (w_up_found) begin
      w_adv_state = StLoad;
      w_adv_cur   = w_up_idx;
    end else if (i_continuous && w_low_found) begin
      w_adv_state = StLoad;
      w_adv_cur   = w_low_idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_freq_nxt  = r_freq;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_abort_nxt = r_abort | i_abort;
    case (r_state)
      StIdle: begin
        if (i_start && !i_abort) begin
          if (w_low_found) begin
            w_state_nxt = StLoad;
            w_cur_nxt   = w_low_idx;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      StLoad: begin
        if (w_abort_req) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = StSend;
          w_freq_nxt  = w_rd_start;
        end
      end
      StSend: begin
        // An abort never withdraws a presented beat; it waits for the handshake.
        if (w_hs) begin
          if (w_abort_req) begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end else if (r_dwell != '0) begin
            w_state_nxt = StDwell;
            w_cnt_nxt   = r_dwell;
          end else begin
            w_state_nxt = w_adv_state;
            w_cur_nxt   = w_adv_cur;
            w_freq_nxt  = w_adv_freq;
          end
        end
      end
      StDwell: begin
        if (w_abort_req) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end else if (r_cnt <= DWELL_W'(1)) begin
          w_state_nxt = w_adv_state;
          w_cur_nxt   = w_adv_cur;
          w_freq_nxt  = w_adv_freq;
        end else begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end
      end
      StFinish: w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
    if (w_state_nxt == StIdle) begin
      w_abort_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cur   <= '0;
      r_freq  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_stop  <= '0;
      r_step  <= '0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_freq  <= w_freq_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
      if (r_state == StLoad) begin
        r_stop  <= w_rd_stop;
        r_step  <= w_rd_step;
        r_dwell <= w_rd_dwell;
      end
    end
  end

  assign o_busy                = (r_state != StIdle);
  assign o_done                = (r_state == StFinish) | r_done;
  assign o_cur_profile         = r_cur;
  assign o_m_axis_phase_tvalid = (r_state == StSend);
  assign o_m_axis_phase_tdata  = (r_state == StSend) ? r_freq : '0;
  assign o_m_axis_phase_tlast  = (r_state == StSend) & w_last;

endmodule

// File: tb/tb_dds_sweep_scheduler.sv
// Bench for the sweep scheduler: a beat-list model predicts every run, a
// per-cycle monitor compares against it, and directed cases cover abort/reset.
module tb_dds_sweep_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_profile;
  logic [1:0]  cfg_field;
  logic [31:0] cfg_wdata;
  logic [3:0]  enable_mask;
  logic        continuous;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  cur;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;

  always #5 clk = ~clk;

  dds_sweep_scheduler #(
    .NUM_PROFILES (4),
    .PINC_W       (32),
    .DWELL_W      (16)
  ) dut (
    .i_clk                 (clk),
    .i_reset               (reset),
    .i_cfg_we              (cfg_we),
    .i_cfg_profile         (cfg_profile),
    .i_cfg_field           (cfg_field),
    .i_cfg_wdata           (cfg_wdata),
    .i_enable_mask         (enable_mask),
    .i_continuous          (continuous),
    .i_start               (start),
    .i_abort               (abort),
    .o_busy                (busy),
    .o_done                (done),
    .o_cur_profile         (cur),
    .o_m_axis_phase_tvalid (tvalid),
    .i_m_axis_phase_tready (tready),
    .o_m_axis_phase_tdata  (tdata),
    .o_m_axis_phase_tlast  (tlast)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          prof;
    int          gap;
  } beat_t;

  beat_t       q[$];
  logic [31:0] m_start[4];
  logic [31:0] m_stop[4];
  logic [31:0] m_step[4];
  logic [15:0] m_dwell[4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, ref_cyc = 0, run_start = -1, done_at = -1, done_gap = 0;
  bit chk_en = 0, in_beat = 0, armed = 0;
  int tr_mode = 0, stall_left = 0;

  logic [31:0] log_data[$];
  logic        log_last[$];
  int          log_prof[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected beat list for one non-continuous run, straight from the sweep rules.
  function automatic void build(input logic [3:0] mask);
    int          prev_d = 0;
    bit          first = 1;
    logic [31:0] f;
    logic [32:0] s;
    logic        last;
    int          k;
    beat_t       b;
    for (int p = 0; p < 4; p++) begin
      if (mask[p]) begin
        f = m_start[p];
        k = 0;
        do begin
          s    = {1'b0, f} + {1'b0, m_step[p]};
          last = (m_step[p] == 0) || (s > {1'b0, m_stop[p]});
          b.data = f;
          b.last = last;
          b.prof = p;
          if (first)       b.gap = 2;
          else if (k == 0) b.gap = (prev_d > 0) ? prev_d + 2 : 2;
          else             b.gap = int'(m_dwell[p]) + 1;
          q.push_back(b);
          first = 0;
          k++;
          f = f + m_step[p];
        end while (!last);
        prev_d = int'(m_dwell[p]);
      end
    end
    done_gap = (prev_d > 0) ? prev_d + 1 : 1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (tvalid && tready) begin
      log_data.push_back(tdata);
      log_last.push_back(tlast);
      log_prof.push_back(int'(cur));
    end
    if (chk_en) begin
      if (armed && start) begin
        armed     = 0;
        run_start = cyc;
        ref_cyc   = cyc;
      end
      check("busy", busy, (run_start >= 0 && cyc > run_start && (done_at < 0 || cyc <= done_at)));
      check("done", done, (done_at >= 0 && cyc == done_at));
      if (tvalid) begin
        if (q.size() == 0) begin
          check("spurious_tvalid", tvalid, 0);
        end else begin
          if (!in_beat) begin
            in_beat = 1;
            check("beat_gap", cyc - ref_cyc, q[0].gap);
          end
          check("tdata", tdata, q[0].data);
          check("tlast", tlast, q[0].last);
          check("cur_profile", cur, q[0].prof);
          if (tready) begin
            void'(q.pop_front());
            in_beat = 0;
            ref_cyc = cyc;
            if (q.size() == 0) done_at = cyc + done_gap;
          end
        end
      end else if (in_beat) begin
        check("tvalid_held", tvalid, 1);
      end
      if (done_at >= 0 && cyc == done_at) begin
        run_start = -1;
        done_at   = -1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (tr_mode)
      1: tready = ($urandom % 4) != 0;
      2: begin
        if (tvalid && log_data.size() == 1 && stall_left > 0) begin
          tready = 1'b0;
          stall_left--;
        end else begin
          tready = 1'b1;
        end
      end
      3: tready = 1'b0;
      default: tready = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_write(input int p, input int f, input logic [31:0] d);
    cfg_we      = 1'b1;
    cfg_profile = p[1:0];
    cfg_field   = f[1:0];
    cfg_wdata   = d;
    tick();
    cfg_we = 1'b0;
    case (f)
      0: m_start[p] = d;
      1: m_stop[p]  = d;
      2: m_step[p]  = d;
      default: m_dwell[p] = d[15:0];
    endcase
  endtask

  task automatic set_prof(input int p, input logic [31:0] st, input logic [31:0] sp,
                          input logic [31:0] stp, input logic [31:0] dw);
    cfg_write(p, 0, st);
    cfg_write(p, 1, sp);
    cfg_write(p, 2, stp);
    cfg_write(p, 3, dw);
  endtask

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
    log_prof.delete();
  endtask

  task automatic run_checked(input logic [3:0] mask, input string tag);
    int n;
    q.delete();
    clear_log();
    build(mask);
    in_beat     = 0;
    done_at     = -1;
    armed       = 1;
    chk_en      = 1;
    enable_mask = mask;
    continuous  = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while ((armed || run_start >= 0) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) begin
      n_fail++;
      $display("FAIL %s_timeout: run still active after %0d cycles", tag, n);
    end
    tick();
    chk_en = 0;
    armed  = 0;
  endtask

  task automatic wait_tvalid(input string tag);
    int n = 0;
    while (!tvalid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_tvalid_seen"}, tvalid, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] e_data[4];
    logic [3:0]  rmask;
    int          n;
    reset = 1'b1; cfg_we = 1'b0; cfg_profile = '0; cfg_field = '0; cfg_wdata = '0;
    enable_mask = '0; continuous = 1'b0; start = 1'b0; abort = 1'b0; tready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      m_start[p] = '0; m_stop[p] = '0; m_step[p] = '0; m_dwell[p] = '0;
    end
    repeat (3) tick();
    sample();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_cur", cur, 0);
    tick();
    reset = 1'b0;
    tick();

    // Basic sweep with dwell 2.
    set_prof(0, 100, 130, 10, 2);
    run_checked(4'b0001, "t1");
    e_data = '{100, 110, 120, 130};
    check("t1_nbeats", log_data.size(), 4);
    for (int i = 0; i < 4 && i < log_data.size(); i++) begin
      check("t1_data", log_data[i], e_data[i]);
      check("t1_last", log_last[i], (i == 3));
    end

    // Carry out of the top of the range ends the profile.
    set_prof(0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1);
    run_checked(4'b0001, "t2");
    check("t2_nbeats", log_data.size(), 1);
    if (log_data.size() > 0) begin
      check("t2_data", log_data[0], 32'hFFFF_FFF0);
      check("t2_last", log_last[0], 1);
    end

    // Second beat stalled for five cycles.
    set_prof(0, 100, 130, 10, 2);
    tr_mode    = 2;
    stall_left = 5;
    run_checked(4'b0001, "t3");
    tr_mode = 0;
    check("t3_stalls_used", stall_left, 0);
    check("t3_nbeats", log_data.size(), 4);
    for (int i = 0; i < 4 && i < log_data.size(); i++) check("t3_data", log_data[i], e_data[i]);

    // Two sparse profiles visited round-robin.
    set_prof(1, 10, 20, 10, 0);
    set_prof(3, 5, 5, 1, 0);
    run_checked(4'b1010, "t4");
    check("t4_nbeats", log_data.size(), 3);
    if (log_data.size() == 3) begin
      check("t4_d0", log_data[0], 10); check("t4_l0", log_last[0], 0); check("t4_p0", log_prof[0], 1);
      check("t4_d1", log_data[1], 20); check("t4_l1", log_last[1], 1); check("t4_p1", log_prof[1], 1);
      check("t4_d2", log_data[2], 5);  check("t4_l2", log_last[2], 1); check("t4_p2", log_prof[2], 3);
    end

    // Randomized runs against the model with random back-pressure.
    tr_mode = 1;
    for (int r = 0; r < 20; r++) begin
      for (int p = 0; p < 4; p++) begin
        logic [31:0] st, sp, stp;
        st = $urandom;
        if ($urandom % 6 == 0) st = 32'hFFFF_FF00 + ($urandom % 256);
        sp  = ($urandom % 8 == 0) ? st - ($urandom % 20) : st + ($urandom % 61);
        stp = ($urandom % 8 == 0) ? 32'hF000_0000 : ($urandom % 16);
        set_prof(p, st, sp, stp, $urandom % 4);
      end
      rmask = 4'($urandom_range(1, 15));
      run_checked(rmask, "rand");
    end
    tr_mode = 0;

    // Continuous single-point sweep, aborted during dwell.
    set_prof(0, 77, 50, 0, 3);
    clear_log();
    enable_mask = 4'b0001;
    continuous  = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (log_data.size() < 3 && n < 500) begin
      tick();
      n++;
    end
    check("t5_repeats", log_data.size() >= 3, 1);
    for (int i = 0; i < 3 && i < log_data.size(); i++) begin
      check("t5_data", log_data[i], 77);
      check("t5_last", log_last[i], 1);
    end
    n = 0;
    do begin
      sample();
      n++;
    end while (!(tvalid && tready) && n < 50);
    tick();
    check("t5_in_dwell", tvalid, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sample();
    check("t5_abort_tvalid", tvalid, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_done", done, 1);
    tick();
    sample();
    check("t5_done_pulse", done, 0);
    continuous = 1'b0;
    n = log_data.size();
    repeat (10) tick();
    check("t5_no_more_beats", log_data.size(), n);

    // Abort while a beat is stalled: beat must stay up until accepted.
    set_prof(0, 100, 130, 10, 0);
    clear_log();
    tr_mode = 3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_tvalid("t6");
    abort = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t6_held_tvalid", tvalid, 1);
      check("t6_held_tdata", tdata, 100);
      if (i == 3) tr_mode = 0;
      tick();
      abort = 1'b0;
    end
    sample();
    check("t6_hs", tvalid && tready, 1);
    tick();
    sample();
    check("t6_idle_tvalid", tvalid, 0);
    check("t6_idle_busy", busy, 0);
    check("t6_done", done, 1);
    repeat (10) tick();
    check("t6_nbeats", log_data.size(), 1);

    // Start with an empty mask: done only.
    clear_log();
    enable_mask = 4'b0000;
    start       = 1'b1;
    tick();
    start = 1'b0;
    sample();
    check("t7_done", done, 1);
    check("t7_busy", busy, 0);
    tick();
    sample();
    check("t7_done_pulse", done, 0);
    check("t7_nbeats", log_data.size(), 0);

    // Start and abort together: nothing happens.
    enable_mask = 4'b0001;
    start       = 1'b1;
    abort       = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t8_busy", busy, 0);
      check("t8_done", done, 0);
      tick();
    end

    // Reset mid-sweep drops tvalid and clears the profile registers.
    set_prof(2, 500, 900, 7, 1);
    enable_mask = 4'b0100;
    tr_mode     = 3;
    start       = 1'b1;
    tick();
    start = 1'b0;
    wait_tvalid("t9");
    check("t9_cur", cur, 2);
    reset = 1'b1;
    tick();
    sample();
    check("t9_rst_tvalid", tvalid, 0);
    check("t9_rst_busy", busy, 0);
    check("t9_rst_cur", cur, 0);
    check("t9_rst_tdata", tdata, 0);
    reset   = 1'b0;
    tr_mode = 0;
    for (int p = 0; p < 4; p++) begin
      m_start[p] = '0; m_stop[p] = '0; m_step[p] = '0; m_dwell[p] = '0;
    end
    tick();
    run_checked(4'b0100, "t9");
    check("t9_nbeats", log_data.size(), 1);
    if (log_data.size() > 0) check("t9_cleared_start", log_data[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
